bus_arbiter: RTL

//  Sits upstream of every master on the serial bus: decodes each master's serial

---
 rtl/bus_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
//==============================================================================
// Module  : bus_arbiter
// Brief   : Decodes serial per-master request frames and grants the shared bus
//           round-robin, one master at a time, driving master/slave mux selects.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module bus_arbiter #(
    parameter int MASTERS  = 2,
    parameter int SLAVES   = 3,
    parameter int ID_WIDTH = 2,
    localparam int MSW     = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [MASTERS-1:0] arbSend,
    output logic [MASTERS-1:0] arbCont,
    output logic [MSW-1:0]     masterSel,
    output logic [ID_WIDTH-1:0] slaveSel,
    output logic               busy
);

    localparam int CNT_W = $clog2(ID_WIDTH + 1);

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        RX_ID   = 3'd1,
        RX_CHK  = 3'd2,
        RX_PEND = 3'd3,
        RX_OWN  = 3'd4,
        RX_DROP = 3'd5
    } rx_state_t;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_GRANT = 2'd1,
        A_GAP   = 2'd2
    } arb_state_t;

    arb_state_t                         arb_state;
    logic [MSW-1:0]                     rr_ptr;
    logic [MASTERS-1:0]                 pending;
    logic [MASTERS-1:0]                 owning;
    logic [MASTERS-1:0]                 take;
    logic [MASTERS-1:0][ID_WIDTH-1:0]   rx_ids;
    logic                               pick_valid;
    logic [MSW-1:0]                     pick;
    logic                               arb_free;

    // ---------------- per-master frame receivers ----------------
    for (genvar m = 0; m < MASTERS; m++) begin : g_rx
        rx_state_t           state;
        logic [ID_WIDTH-1:0] id_q;
        logic [CNT_W-1:0]    cnt;
        logic                id_ok;

        assign id_ok     = (id_q != '0) && (int'(id_q) <= SLAVES);
        // A pending master whose line has already fallen is cancelling, not eligible.
        assign pending[m] = (state == RX_PEND) && arbSend[m];
        assign owning[m]  = (state == RX_OWN);
        assign rx_ids[m]  = id_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state <= RX_IDLE;
                id_q  <= '0;
                cnt   <= '0;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (arbSend[m]) begin
                            state <= RX_ID;
                            cnt   <= '0;
                        end
                    end
                    RX_ID: begin
                        id_q <= ID_WIDTH'({id_q, arbSend[m]});
                        cnt  <= cnt + 1'b1;
                        if (cnt == CNT_W'(ID_WIDTH - 1)) state <= RX_CHK;
                    end
                    RX_CHK: begin
                        if (!arbSend[m])  state <= RX_IDLE;
                        else if (id_ok)   state <= RX_PEND;
                        else              state <= RX_DROP;
                    end
                    RX_PEND: begin
                        if (!arbSend[m])  state <= RX_IDLE;
                        else if (take[m]) state <= RX_OWN;
                    end
                    RX_OWN, RX_DROP: begin
                        if (!arbSend[m])  state <= RX_IDLE;
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

    // ---------------- round-robin selection ----------------
    always_comb begin
        pick_valid = 1'b0;
        pick       = '0;
        for (int k = 0; k < MASTERS; k++) begin
            if (!pick_valid && pending[(int'(rr_ptr) + k) % MASTERS]) begin
                pick_valid = 1'b1;
                pick       = MSW'((int'(rr_ptr) + k) % MASTERS);
            end
        end
    end

    // GAP may grant directly so that exactly one all-zero cycle separates owners.
    assign arb_free = (arb_state != A_GRANT);

    always_comb begin
        take = '0;
        if (arb_free && pick_valid) take[pick] = 1'b1;
    end

    // ---------------- grant FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arb_state <= A_IDLE;
            arbCont   <= '0;
            masterSel <= '0;
            slaveSel  <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            case (arb_state)
                A_IDLE, A_GAP: begin
                    if (pick_valid) begin
                        arb_state <= A_GRANT;
                        arbCont   <= take;
                        busy      <= 1'b1;
                        masterSel <= pick;
                        slaveSel  <= rx_ids[pick];
                    end else begin
                        arb_state <= A_IDLE;
                    end
                end
                A_GRANT: begin
                    if (owning[masterSel] && !arbSend[masterSel]) begin
                        arb_state <= A_GAP;
                        arbCont   <= '0;
                        busy      <= 1'b0;
                        rr_ptr    <= (masterSel == MSW'(MASTERS - 1)) ? '0 : masterSel + 1'b1;
                    end
                end
                default: arb_state <= A_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
